// File: rtl/mem_pkg.sv
// Shared memory-port definitions: default widths, read-owner encoding, word-address helper.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W     = 32;
    localparam int unsigned MEM_DATA_W     = 32;
    localparam int unsigned MEM_MAX_ADDR_W = 64;

    // Which requester owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_I    = 2'd1,
        RD_D    = 2'd2
    } rd_owner_t;

    // Byte address to word address ({2'b00, addr[W-1:2]}); callers truncate to their width.
    function automatic logic [MEM_MAX_ADDR_W-1:0] word_addr(input logic [MEM_MAX_ADDR_W-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch port (I) and the load/store port (D).
// D has priority; after MAX_D_RUN back-to-back D grants with I waiting, I is forced through.
// Read data returns one cycle after the grant, steered by the registered read owner.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_D_RUN + 1);

    logic [CNT_W-1:0]  run_cnt;
    rd_owner_t         rd_owner;
    logic              force_i;
    logic [ADDR_W-1:0] sel_addr;

    // Grant selection and RAM request formation; nothing is granted while in reset.
    always_comb begin
        force_i  = 1'b0;
        d_gnt    = 1'b0;
        i_gnt    = 1'b0;
        sel_addr = i_addr;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;

        force_i  = i_req && (run_cnt == CNT_W'(MAX_D_RUN));
        d_gnt    = resetn && d_req && !force_i;
        i_gnt    = resetn && i_req && !d_gnt;
        sel_addr = d_gnt ? d_addr : i_addr;
        ram_en   = i_gnt || d_gnt;
        ram_we   = d_gnt && d_we;
        if (ram_en) begin
            ram_addr = ADDR_W'(word_addr(MEM_MAX_ADDR_W'(sel_addr)));
        end
    end

    // D-run counter (saturating) and read-data owner for the next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_cnt  <= '0;
            rd_owner <= RD_NONE;
        end else begin
            if (i_gnt || !i_req) begin
                run_cnt <= '0;
            end else if (d_gnt && (run_cnt != CNT_W'(MAX_D_RUN))) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end

            if (i_gnt) begin
                rd_owner <= RD_I;
            end else if (d_gnt && !d_we) begin
                rd_owner <= RD_D;
            end else begin
                rd_owner <= RD_NONE;
            end
        end
    end

    // Return path: data is shared, valids say whose it is.
    assign i_rvalid  = (rd_owner == RD_I);
    assign d_rvalid  = (rd_owner == RD_D);
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;
    assign ram_wdata = d_wdata;

endmodule
